// File: rtl/fir_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_filter_pkg
// Description : Shared sizing, types and MAC state encoding for the FIR filter.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_filter_pkg;

  localparam int NTAPS     = 8;
  localparam int FADDRBITS = 3;
  localparam int PRODW     = 32;
  localparam int FRACBITS  = 15;
  // Headroom of FADDRBITS guard bits keeps NTAPS full-scale products exact.
  localparam int ACCW      = PRODW + FADDRBITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_mac_state_t;

  typedef logic signed [15:0]     sample_t;
  typedef logic signed [ACCW-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/fir_sat.sv
`default_nettype none
// ============================================================================
// Module      : fir_sat
// Description : Scales a Q-format accumulator back to Q1.15 (floor shift by 15)
//               and saturates the result to the signed 16-bit range.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sat
  import fir_filter_pkg::*;
#(
  parameter int ACC_W = ACCW
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [15:0]      sat_out
);

  localparam logic signed [ACC_W-1:0] c_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] c_MIN = ACC_W'(-32768);

  logic signed [ACC_W-1:0] w_shifted;

  // Arithmetic shift rounds toward minus infinity, matching plain truncation.
  assign w_shifted = acc_in >>> FRACBITS;

  // Clamp to the representable Q1.15 range.
  always_comb begin
    sat_out = w_shifted[15:0];
    if (w_shifted > c_MAX) begin
      sat_out = 16'sh7FFF;
    end else if (w_shifted < c_MIN) begin
      sat_out = 16'sh8000;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac
// Description : Time-multiplexed FIR multiply-accumulate. Accepts one sample,
//               walks the coefficient bank one tap per cycle and emits one
//               saturated Q1.15 result per input sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac
  import fir_filter_pkg::*;
#(
  parameter int NTAPS     = fir_filter_pkg::NTAPS,
  parameter int FADDRBITS = fir_filter_pkg::FADDRBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  output logic [FADDRBITS-1:0] faddr_out,
  input  logic [15:0]          coeff_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic                 busy_out
);

  localparam int                   c_ACCW     = PRODW + FADDRBITS;
  localparam logic [FADDRBITS-1:0] c_LAST_TAP = FADDRBITS'(NTAPS - 1);

  fir_mac_state_t          r_state;
  fir_mac_state_t          w_state_next;
  sample_t                 r_x [NTAPS];
  logic signed [c_ACCW-1:0] r_acc;
  logic [FADDRBITS-1:0]    r_tap;
  logic [15:0]             r_out_data;

  logic                    w_accept;
  logic                    w_last;
  sample_t                 w_x_tap;
  logic signed [PRODW-1:0] w_prod;
  logic signed [c_ACCW-1:0] w_acc_sum;
  logic signed [15:0]      w_sat;

  assign w_last    = (r_tap == c_LAST_TAP);
  assign w_x_tap   = r_x[r_tap];
  assign w_prod    = $signed(coeff_in) * w_x_tap;
  assign w_acc_sum = r_acc + {{(c_ACCW-PRODW){w_prod[PRODW-1]}}, w_prod};
  assign w_accept  = in_valid && in_ready;
  assign out_data  = r_out_data;

  // The final tap's sum is saturated directly so the result is ready on MAC->OUT.
  fir_sat #(
    .ACC_W (c_ACCW)
  ) u_sat (
    .acc_in  (w_acc_sum),
    .sat_out (w_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake/bank-address outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    faddr_out    = '0;
    busy_out     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          w_state_next = MAC;
        end
      end
      MAC: begin
        faddr_out = r_tap;
        busy_out  = 1'b1;
        if (w_last) begin
          w_state_next = OUT;
        end
      end
      OUT: begin
        busy_out  = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Delay line, accumulator, tap counter and output result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_x[i] <= '0;
      end
      r_acc      <= '0;
      r_tap      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x[0] <= $signed(in_data);
            for (int i = 1; i < NTAPS; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc <= '0;
            r_tap <= '0;
          end
        end
        MAC: begin
          r_acc <= w_acc_sum;
          if (w_last) begin
            r_out_data <= w_sat;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac
// Description : Directed self-checking bench for fir_mac with a coefficient
//               bank model driving coeff_in from faddr_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac;

  localparam int NT    = 8;
  localparam int LIMIT = 50;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] in_data   = '0;
  logic [2:0]  faddr_out;
  logic [15:0] coeff_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy_out;

  logic [15:0] h [NT];
  int          tests = 0;
  int          fails = 0;

  typedef struct packed {
    logic [15:0] hv;
    logic [15:0] xv;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  // Coefficient bank model: combinational read of the addressed tap.
  always_comb coeff_in = h[faddr_out];

  fir_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .faddr_out (faddr_out),
    .coeff_in  (coeff_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy_out  (busy_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic set_h_all(input logic [15:0] v);
    for (int k = 0; k < NT; k++) h[k] = v;
  endtask

  task automatic set_h_ramp();
    for (int k = 0; k < NT; k++) h[k] = 16'((k + 1) * 16'h0100);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen high.
  task automatic send(input logic [15:0] x, output logic [15:0] y);
    int n;
    y        = 'x;
    in_valid = 1'b1;
    in_data  = x;
    n = 0;
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("out_valid_timeout", 0, 1);
    y = out_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] y;
    logic [15:0] held;
    logic        seen;
    int          n;

    vecs[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[1] = '{16'h8000, 16'h8000, 16'h7FFF};
    vecs[2] = '{16'h7FFF, 16'h8000, 16'h8000};
    vecs[3] = '{16'h0100, 16'h0100, 16'h0010};
    vecs[4] = '{16'h2000, 16'h2000, 16'h4000};
    vecs[5] = '{16'h4000, 16'hC000, 16'h8000};
    vecs[6] = '{16'hFFFF, 16'h0001, 16'hFFFF};
    set_h_ramp();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_faddr", 32'(faddr_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Impulse response.
    for (int k = 0; k < NT; k++) begin
      send((k == 0) ? 16'h4000 : 16'h0000, y);
      chk("impulse", 32'(y), 32'((k + 1) * 128));
    end
    send(16'h0000, y);
    chk("impulse_tail", 32'(y), 0);

    // Sequencing and latency.
    @(negedge clk);
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NT; i++) begin
      chk("seq_faddr", 32'(faddr_out), 32'(i));
      chk("seq_no_valid", 32'(out_valid), 0);
      chk("seq_busy", 32'(busy_out), 1);
      @(negedge clk);
    end
    chk("seq_out_valid", 32'(out_valid), 1);
    chk("seq_busy_out", 32'(busy_out), 1);
    chk("seq_faddr_out_state", 32'(faddr_out), 0);
    @(negedge clk);
    chk("seq_busy_done", 32'(busy_out), 0);
    chk("seq_valid_done", 32'(out_valid), 0);

    // Table-driven saturation / arithmetic vectors.
    for (int v = 0; v < 7; v++) begin
      set_h_all(vecs[v].hv);
      for (int s = 0; s < NT; s++) begin
        send(vecs[v].xv, y);
      end
      chk($sformatf("vec%0d", v), 32'(y), 32'(vecs[v].exp_y));
    end

    // Backpressure.
    @(negedge clk);
    do_reset();
    set_h_ramp();
    out_ready = 1'b0;
    send(16'h4000, y);
    chk("bp_first", 32'(y), 128);
    held     = out_data;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", 32'(out_valid), 0);
    chk("bp_idle_ready", 32'(in_ready), 1);
    chk("bp_hold_data", 32'(out_data), 32'(held));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy_out), 1);
    chk("bp_accept_faddr", 32'(faddr_out), 0);
    n = 0;
    while (!out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second", 32'(out_data), 256);

    // Reset mid-MAC.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (faddr_out != 3'd3 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("mid_faddr3", 32'(faddr_out), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy_out), 0);
    chk("mid_faddr", 32'(faddr_out), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_in_ready", 32'(in_ready), 0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_never_valid", 32'(seen), 0);
    send(16'h4000, y);
    chk("mid_impulse", 32'(y), 128);
    send(16'h0000, y);
    chk("mid_impulse2", 32'(y), 256);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac.md
Name: fir_mac

Overview:
- Time-multiplexed multiply-accumulate stage of the FIR filter.
- Sits directly downstream of the coefficient register bank, and also drives that bank's tap address.
- Accepts one 16-bit signed sample per valid/ready handshake and shifts it into an NTAPS-deep delay line.
- Walks the tap address 0..NTAPS-1, one tap per cycle, multiplying each returned coefficient by the matching delayed sample, then emits one saturated Q1.15 result per input sample.

Parameters:
- NTAPS, default fir_filter_pkg::NTAPS (8): number of filter taps and delay-line depth.
- FADDRBITS, default fir_filter_pkg::FADDRBITS (3): tap address width; must satisfy 2**FADDRBITS >= NTAPS.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset. The codebase base name is kept; the _n suffix is dropped because polarity is high.
- in_valid, input, 1: sample on in_data is valid.
- in_ready, output, 1: block can accept a sample.
- in_data, input, 16: signed Q1.15 input sample.
- faddr_out, output, FADDRBITS: tap address to the coefficient bank.
- coeff_in, input, 16: signed Q1.15 coefficient, combinationally returned for faddr_out in the same cycle.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, 16: signed Q1.15 filter output.
- busy_out, output, 1: a computation is in progress. The controller must not pulse the bank's load enable while this is high.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; delay line x[0..NTAPS-1]=0; acc=0; tap=0.
  - out_valid=0, out_data=0, faddr_out=0, busy_out=0.
  - in_ready is held 0 while rst=1.
  - Reset wins over every other event, including mid-MAC and mid-OUT; any partial result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: x[0]<=in_data, x[i]<=x[i-1], acc<=0, tap<=0, go to MAC.
  - MAC: faddr_out=tap, busy_out=1. acc<=acc+coeff_in*x[tap] (full signed product). If tap==NTAPS-1 go to OUT, else tap<=tap+1.
  - OUT: out_valid=1, out_data holds the registered saturated result, busy_out=1. On out_ready go to IDLE. in_ready=0 and in_valid is ignored.
- Arithmetic:
  - Product width is 32 bits signed.
  - Accumulator width is ACCW=32+FADDRBITS bits signed, so the accumulation itself never overflows.
  - Result = acc >>> 15 (truncation toward -inf).
  - Saturate to [-32768, 32767]. Register the result into out_data on the MAC->OUT transition.
- Latency:
  - Accept edge E0; MAC at edges E0+1..E0+NTAPS.
  - out_valid high in the cycle after E0+NTAPS.
  - Minimum sample period is NTAPS+2 cycles.
- faddr_out is 0 outside MAC and never exceeds NTAPS-1.
- out_data holds its last value after the handshake until the next result; out_valid drops.
- The delay line is modified only on accept.

Decomposition:
- fir_filter_pkg gains:
  - ACCW;
  - a state enum fir_mac_state_t {IDLE, MAC, OUT};
  - typedefs sample_t (logic signed [15:0]) and acc_t (logic signed [ACCW-1:0]).
- One natural sub-module: fir_sat, combinational, acc_t in -> shift by 15 -> saturated 16-bit out. It is reused by later output stages.

Test Plan:
All scenarios assume NTAPS=8 and a coefficient bank model driving coeff_in from faddr_out.

- Reset: hold rst=1 for 3 cycles -> out_valid=0, out_data=0, faddr_out=0, busy_out=0, in_ready=0. One cycle after release -> in_ready=1.
- Impulse: set h[k]=(k+1)*0x0100, send 0x4000 then seven 0x0000 samples (out_ready=1) -> out_data sequence 128, 256, 384, 512, 640, 768, 896, 1024; a ninth zero sample -> 0.
- Sequencing and latency: one accept -> faddr_out steps 0,1,...,7 on consecutive cycles; out_valid rises exactly 8 cycles after the accept edge; busy_out high for 9 cycles.
- Saturation:
  - all h=0x7FFF with eight 0x7FFF samples -> 0x7FFF;
  - all h=0x8000 with eight 0x8000 samples -> 0x7FFF;
  - all h=0x7FFF with eight 0x8000 samples -> 0x8000.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid and out_data stable, in_ready=0, no sample consumed. Raise out_ready -> IDLE next cycle; the pending sample is accepted the following cycle.
- Reset mid-MAC: assert rst while faddr_out=3 -> next cycle IDLE, out_valid never asserted, delay line cleared. The impulse from the Impulse scenario afterwards -> first output 128.
